// File: rtl/uart_rx_mini.sv
// uart_rx_mini: 8N1 serial receiver with a small FIFO and a zero-wait APB slave.
//   clk, rst_n          : clock, asynchronous active-low reset
//   apbs_*              : APB slave (DATA @0x0 pops the FIFO head, STATUS @0x4)
//   rx                  : serial input, idles high, asynchronous to clk
//   rts                 : 1 = peer may send (registered from next FIFO level)
//   irq                 : not_empty | frame_err | overrun
//   dreq                : FIFO not empty
module uart_rx_mini #(
  parameter int unsigned BIT_CYCLES = 868,
  parameter int unsigned DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        apbs_psel,
  input  logic        apbs_penable,
  input  logic        apbs_pwrite,
  input  logic [15:0] apbs_paddr,
  input  logic [31:0] apbs_pwdata,
  output logic [31:0] apbs_prdata,
  output logic        apbs_pready,
  output logic        apbs_pslverr,
  input  logic        rx,
  output logic        rts,
  output logic        irq,
  output logic        dreq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [31:0]   HALF_LOAD = 32'(BIT_CYCLES / 2 - 1);
  localparam logic [31:0]   FULL_LOAD = 32'(BIT_CYCLES - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] RTS_MAX   = LW'(DEPTH - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
  } state_t;

  // Synchronizer
  logic sync1_q, sync2_q, rxs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  assign rxs = sync2_q;

  // Receive FSM
  state_t      state_q;
  logic [31:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        cnt_zero, stop_sample, push, ferr_set;

  assign cnt_zero    = (cnt_q == '0);
  assign stop_sample = (state_q == S_STOP) && cnt_zero;
  assign push        = stop_sample && rxs;
  assign ferr_set    = stop_sample && !rxs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            state_q <= S_START;
            cnt_q   <= HALF_LOAD;
          end
        end
        S_START: begin
          if (cnt_zero) begin
            if (!rxs) begin
              state_q   <= S_DATA;
              bit_idx_q <= '0;
              cnt_q     <= FULL_LOAD;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        S_DATA: begin
          if (cnt_zero) begin
            shift_q   <= {rxs, shift_q[7:1]};
            cnt_q     <= FULL_LOAD;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        S_STOP: begin
          if (cnt_zero) state_q <= rxs ? S_IDLE : S_WAIT_IDLE;
          else          cnt_q   <= cnt_q - 32'd1;
        end
        S_WAIT_IDLE: begin
          if (rxs) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // APB decode
  logic       access, rd, wr;
  logic [1:0] sel;

  assign access = apbs_psel && apbs_penable;
  assign rd     = access && !apbs_pwrite;
  assign wr     = access && apbs_pwrite;
  assign sel    = apbs_paddr[3:2];

  // FIFO
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          not_empty, full, pop, push_ok, ovr_set;
  logic          ferr_q, ovr_q, rts_q;
  logic          ferr_clr, ovr_clr;

  assign not_empty = (level_q != '0);
  assign full      = (level_q == LVL_FULL);
  assign pop       = rd && (sel == 2'd0) && not_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = push && (!full || pop);
  assign ovr_set   = push && full && !pop;
  assign ferr_clr  = wr && (sel == 2'd1) && apbs_pwdata[2];
  assign ovr_clr   = wr && (sel == 2'd1) && apbs_pwdata[3];

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      rts_q   <= 1'b1;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop)     rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
      // A new error event wins over a clear in the same cycle.
      ferr_q  <= ferr_set || (ferr_q && !ferr_clr);
      ovr_q   <= ovr_set  || (ovr_q  && !ovr_clr);
      rts_q   <= (level_d <= RTS_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= shift_q;
  end

  // Read data
  always_comb begin
    apbs_prdata = '0;
    case (sel)
      2'd0: if (not_empty) apbs_prdata[7:0] = mem_q[rptr_q];
      2'd1: begin
        apbs_prdata[0]   = not_empty;
        apbs_prdata[1]   = full;
        apbs_prdata[2]   = ferr_q;
        apbs_prdata[3]   = ovr_q;
        apbs_prdata[7:4] = 4'(level_q);
      end
      default: apbs_prdata = '0;
    endcase
  end

  assign apbs_pready  = 1'b1;
  assign apbs_pslverr = 1'b0;
  assign rts          = rts_q;
  assign irq          = not_empty || ferr_q || ovr_q;
  assign dreq         = not_empty;

  logic unused_bits;
  assign unused_bits = ^{apbs_paddr[15:4], apbs_paddr[1:0],
                         apbs_pwdata[31:4], apbs_pwdata[1:0]};

endmodule

// File: tb/tb_uart_rx_mini.sv
// Testbench for uart_rx_mini (BIT_CYCLES = 16, DEPTH = 4).
module tb_uart_rx_mini;

  localparam int unsigned BITC = 16;
  localparam int unsigned DEP  = 4;

  logic        clk;
  logic        rst_n;
  logic        apbs_psel, apbs_penable, apbs_pwrite;
  logic [15:0] apbs_paddr;
  logic [31:0] apbs_pwdata, apbs_prdata;
  logic        apbs_pready, apbs_pslverr;
  logic        rx, rts, irq, dreq;

  uart_rx_mini #(.BIT_CYCLES(BITC), .DEPTH(DEP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .apbs_psel    (apbs_psel),
    .apbs_penable (apbs_penable),
    .apbs_pwrite  (apbs_pwrite),
    .apbs_paddr   (apbs_paddr),
    .apbs_pwdata  (apbs_pwdata),
    .apbs_prdata  (apbs_prdata),
    .apbs_pready  (apbs_pready),
    .apbs_pslverr (apbs_pslverr),
    .rx           (rx),
    .rts          (rts),
    .irq          (irq),
    .dreq         (dreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {K_APB, K_RTS, K_IRQ, K_DREQ, K_PRD} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t expq[$];
  bit   done = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Monitor: APB read data is compared in the access cycle; level probes
  // queued by the stimulus are compared on the next falling edge.
  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      if (apbs_psel && apbs_penable && !apbs_pwrite) begin
        checks++;
        if (expq.size() == 0 || expq[0].kind != K_APB) begin
          errors++;
          $display("FAIL unexpected_read: prdata=%h, no read was expected", apbs_prdata);
        end else begin
          e = expq.pop_front();
          if (apbs_prdata !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, apbs_prdata, e.val);
          end
        end
      end
      while (expq.size() > 0 && expq[0].kind != K_APB) begin
        e = expq.pop_front();
        case (e.kind)
          K_RTS:   act = {31'b0, rts};
          K_IRQ:   act = {31'b0, irq};
          K_DREQ:  act = {31'b0, dreq};
          K_PRD:   act = apbs_prdata;
          default: act = 'x;
        endcase
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
        end
      end
      if (done) begin
        if (expq.size() != 0) begin
          checks++;
          errors++;
          $display("FAIL leftover: %0d expectations unanswered, expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to end earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic probe(input kind_t k, input logic [31:0] v, input string nm);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.name = nm;
    expq.push_back(e);
  endtask

  task automatic apb_read(input logic [15:0] a, input logic [31:0] v, input string nm);
    apbs_psel    = 1'b1;
    apbs_penable = 1'b0;
    apbs_pwrite  = 1'b0;
    apbs_paddr   = a;
    tick(1);
    apbs_penable = 1'b1;
    probe(K_APB, v, nm);
    tick(1);
    apbs_psel    = 1'b0;
    apbs_penable = 1'b0;
  endtask

  task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
    apbs_psel    = 1'b1;
    apbs_penable = 1'b0;
    apbs_pwrite  = 1'b1;
    apbs_paddr   = a;
    apbs_pwdata  = d;
    tick(1);
    apbs_penable = 1'b1;
    tick(1);
    apbs_psel    = 1'b0;
    apbs_penable = 1'b0;
    apbs_pwrite  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len);
    rx = 1'b0;
    tick(BITC);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(BITC);
    end
    rx = stop;
    tick(stop_len);
    rx = 1'b1;
  endtask

  initial begin : stimulus
    rst_n        = 1'b0;
    rx           = 1'b1;
    apbs_psel    = 1'b0;
    apbs_penable = 1'b0;
    apbs_pwrite  = 1'b0;
    apbs_paddr   = 16'h4;
    apbs_pwdata  = '0;
    tick(3);
    probe(K_RTS,  32'h1, "reset_rts");
    probe(K_IRQ,  32'h0, "reset_irq");
    probe(K_DREQ, 32'h0, "reset_dreq");
    probe(K_PRD,  32'h0, "reset_prdata");
    tick(1);
    rst_n = 1'b1;
    tick(3);

    // Single byte
    send_frame(8'hA5, 1'b1, BITC);
    tick(2);
    probe(K_DREQ, 32'h1, "single_dreq_set");
    probe(K_IRQ,  32'h1, "single_irq_set");
    apb_read(16'h4, 32'h11, "single_status");
    apb_read(16'h0, 32'hA5, "single_data");
    apb_read(16'h4, 32'h00, "single_status_after");
    probe(K_IRQ,  32'h0, "single_irq_clear");
    probe(K_DREQ, 32'h0, "single_dreq_clear");
    tick(2);

    // Glitch on an idle line
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(30);
    apb_read(16'h4, 32'h00, "glitch_status");
    probe(K_IRQ, 32'h0, "glitch_irq");
    send_frame(8'h3C, 1'b1, BITC);
    tick(2);
    apb_read(16'h0, 32'h3C, "glitch_next_data");

    // Framing error with the line held low
    send_frame(8'h55, 1'b0, 40);
    tick(20);
    apb_read(16'h4, 32'h04, "ferr_status");
    probe(K_IRQ,  32'h1, "ferr_irq");
    probe(K_DREQ, 32'h0, "ferr_dreq");
    tick(1);
    apb_write(16'h4, 32'h04);
    apb_read(16'h4, 32'h00, "ferr_cleared");
    probe(K_IRQ, 32'h0, "ferr_irq_cleared");
    send_frame(8'h12, 1'b1, BITC);
    tick(2);
    apb_read(16'h0, 32'h12, "ferr_next_data");

    // Overrun and flow control
    send_frame(8'h01, 1'b1, BITC);
    send_frame(8'h02, 1'b1, BITC);
    tick(1);
    probe(K_RTS, 32'h1, "rts_level2");
    send_frame(8'h03, 1'b1, BITC);
    tick(1);
    probe(K_RTS, 32'h0, "rts_level3");
    send_frame(8'h04, 1'b1, BITC);
    send_frame(8'h05, 1'b1, BITC);
    tick(2);
    apb_read(16'h4, 32'h4B, "ovr_status");
    apb_read(16'h0, 32'h01, "ovr_data1");
    probe(K_RTS, 32'h0, "ovr_rts_after_read1");
    apb_read(16'h0, 32'h02, "ovr_data2");
    probe(K_RTS, 32'h1, "ovr_rts_after_read2");
    apb_read(16'h0, 32'h03, "ovr_data3");
    apb_read(16'h0, 32'h04, "ovr_data4");
    apb_read(16'h0, 32'h00, "ovr_data_empty");
    apb_read(16'h4, 32'h08, "ovr_sticky");
    probe(K_IRQ, 32'h1, "ovr_irq");
    tick(1);
    apb_write(16'h4, 32'h08);
    apb_read(16'h4, 32'h00, "ovr_cleared");

    // Simultaneous push and pop while full
    send_frame(8'h10, 1'b1, BITC);
    send_frame(8'h11, 1'b1, BITC);
    send_frame(8'h12, 1'b1, BITC);
    send_frame(8'h13, 1'b1, BITC);
    tick(2);
    apb_read(16'h4, 32'h43, "simul_full_status");
    fork
      send_frame(8'h14, 1'b1, BITC);
      begin
        // Stop bit is sampled on the 155th edge after the start bit is driven.
        tick(153);
        apb_read(16'h0, 32'h10, "simul_pop_data");
      end
    join
    tick(2);
    apb_read(16'h4, 32'h43, "simul_status_no_ovr");
    probe(K_RTS, 32'h0, "simul_rts");
    apb_read(16'h0, 32'h11, "simul_data1");
    apb_read(16'h0, 32'h12, "simul_data2");
    apb_read(16'h0, 32'h13, "simul_data3");
    apb_read(16'h0, 32'h14, "simul_data_new_last");
    apb_read(16'h4, 32'h00, "simul_empty");

    // Reset mid-frame, with a byte left in the FIFO
    send_frame(8'h77, 1'b1, BITC);
    tick(2);
    apbs_paddr = 16'h4;
    fork
      send_frame(8'hFF, 1'b1, BITC);
      begin
        tick(88);
        rst_n = 1'b0;
        tick(2);
        probe(K_RTS,  32'h1, "midrst_rts");
        probe(K_IRQ,  32'h0, "midrst_irq");
        probe(K_DREQ, 32'h0, "midrst_dreq");
        probe(K_PRD,  32'h0, "midrst_prdata");
        tick(1);
        rst_n = 1'b1;
      end
    join
    tick(20);
    apb_read(16'h4, 32'h00, "midrst_status");
    send_frame(8'h81, 1'b1, BITC);
    tick(2);
    apb_read(16'h4, 32'h11, "midrst_next_status");
    apb_read(16'h0, 32'h81, "midrst_next_data");

    tick(3);
    done = 1'b1;
  end

endmodule
